// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: round-robin burst arbiter sharing one fifo write port.
// One requester owns the port at a time. Ownership rotates when the owner
// drops its request or completes BURST_MAX pushes, with one idle cycle
// between grants.
// Optional macro FIFO_ARB_STATS_EN adds 32-bit push_cnt / stall_cnt outputs.
module fifo_rr_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int BURST_MAX = 4,
   parameter int DW        = 32,
   localparam int IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int CW       = $clog2(BURST_MAX + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ*DW-1:0] req_dat,
   output logic [NUM_REQ-1:0]    grant,
   output logic [NUM_REQ-1:0]    accept,
   output logic                  fifo_push,
   output logic [DW-1:0]         fifo_dat_in,
   input  logic                  fifo_full,
   output logic [IW-1:0]         owner_id,
   output logic                  busy
`ifdef FIFO_ARB_STATS_EN
   ,
   output logic [31:0]           push_cnt,
   output logic [31:0]           stall_cnt
`endif
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t               r_state;
   logic [NUM_REQ-1:0]   r_grant;
   logic [IW-1:0]        r_owner_id;
   logic [IW-1:0]        r_rr_ptr;
   logic [CW-1:0]        r_burst_cnt;
   logic                 r_busy;

   logic                 w_own_req;
   logic [DW-1:0]        w_owner_dat;
   logic                 w_push;
   logic                 w_last_push;
   logic                 w_release;
   logic [IW-1:0]        w_next_ptr;
   logic                 w_sel_found;
   logic [IW-1:0]        w_sel_idx;
   logic [NUM_REQ-1:0]   w_sel_onehot;

   // Owner request/data and the push decision; reset suppresses any push.
   always_comb begin
      w_own_req   = req[r_owner_id];
      w_owner_dat = req_dat[int'(r_owner_id)*DW +: DW];
      w_push      = (r_state == ST_BUSY) & w_own_req & ~fifo_full & ~rst;
      w_last_push = w_push & (r_burst_cnt == CW'(BURST_MAX - 1));
      w_release   = (r_state == ST_BUSY) & (~w_own_req | w_last_push);
      if (r_owner_id == IW'(NUM_REQ - 1)) begin
         w_next_ptr = {IW{1'b0}};
      end else begin
         w_next_ptr = r_owner_id + {{(IW-1){1'b0}}, 1'b1};
      end
   end

   // Round-robin scan: first set request at or after rr_ptr, wrapping.
   always_comb begin
      logic [IW-1:0] pos;
      logic          hit;
      w_sel_found = 1'b0;
      w_sel_idx   = {IW{1'b0}};
      pos         = {IW{1'b0}};
      hit         = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         pos         = IW'((int'(r_rr_ptr) + k) % NUM_REQ);
         hit         = ~w_sel_found & req[pos];
         w_sel_idx   = hit ? pos : w_sel_idx;
         w_sel_found = w_sel_found | hit;
      end
      w_sel_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel_idx;
   end

   // Arbiter state machine: grant ownership in IDLE, count pushes and release in BUSY.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_grant     <= {NUM_REQ{1'b0}};
         r_owner_id  <= {IW{1'b0}};
         r_rr_ptr    <= {IW{1'b0}};
         r_burst_cnt <= {CW{1'b0}};
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_sel_found) begin
                  r_state     <= ST_BUSY;
                  r_grant     <= w_sel_onehot;
                  r_owner_id  <= w_sel_idx;
                  r_burst_cnt <= {CW{1'b0}};
                  r_busy      <= 1'b1;
               end else begin
                  r_state     <= ST_IDLE;
                  r_busy      <= 1'b0;
               end
            end
            ST_BUSY: begin
               if (w_release) begin
                  r_state     <= ST_IDLE;
                  r_grant     <= {NUM_REQ{1'b0}};
                  r_owner_id  <= {IW{1'b0}};
                  r_burst_cnt <= {CW{1'b0}};
                  r_rr_ptr    <= w_next_ptr;
                  r_busy      <= 1'b0;
               end else if (w_push) begin
                  r_burst_cnt <= r_burst_cnt + {{(CW-1){1'b0}}, 1'b1};
               end else begin
                  r_burst_cnt <= r_burst_cnt;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_grant     <= {NUM_REQ{1'b0}};
               r_owner_id  <= {IW{1'b0}};
               r_burst_cnt <= {CW{1'b0}};
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

`ifdef FIFO_ARB_STATS_EN
   logic [31:0] r_push_cnt;
   logic [31:0] r_stall_cnt;

   // Free-running statistics: total pushes and owner cycles stalled by a full fifo.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_push_cnt  <= 32'd0;
         r_stall_cnt <= 32'd0;
      end else begin
         if (w_push) begin
            r_push_cnt <= r_push_cnt + 32'd1;
         end else begin
            r_push_cnt <= r_push_cnt;
         end
         if ((r_state == ST_BUSY) && w_own_req && fifo_full) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end else begin
            r_stall_cnt <= r_stall_cnt;
         end
      end
   end

   assign push_cnt  = r_push_cnt;
   assign stall_cnt = r_stall_cnt;
`endif

   assign grant       = r_grant;
   assign owner_id    = r_owner_id;
   assign busy        = r_busy;
   assign fifo_push   = w_push;
   assign accept      = w_push ? r_grant : {NUM_REQ{1'b0}};
   assign fifo_dat_in = w_push ? w_owner_dat : {DW{1'b0}};

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Scoreboard bench for fifo_rr_arbiter: directed scenarios queue the
// hand-computed push sequence; a monitor checks every fifo push against it.
module tb_fifo_rr_arbiter;
   localparam int NUM_REQ   = 4;
   localparam int BURST_MAX = 4;
   localparam int DW        = 32;

   typedef struct packed {
      logic [1:0]  idx;
      logic [31:0] dat;
   } exp_t;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NUM_REQ-1:0]    req;
   logic [NUM_REQ*DW-1:0] req_dat;
   logic [NUM_REQ-1:0]    grant;
   logic [NUM_REQ-1:0]    accept;
   logic                  fifo_push;
   logic [DW-1:0]         fifo_dat_in;
   logic                  fifo_full;
   logic [1:0]            owner_id;
   logic                  busy;
`ifdef FIFO_ARB_STATS_EN
   logic [31:0]           push_cnt;
   logic [31:0]           stall_cnt;
`endif

   exp_t        exp_q[$];
   logic [31:0] src_q[NUM_REQ][$];
   logic [3:0]  en;
   logic [3:0]  drv_adv;
   logic [31:0] drv_dummy;
   exp_t        mon_e;
   int          n_checks = 0;
   int          n_errors = 0;

   fifo_rr_arbiter #(.NUM_REQ(NUM_REQ), .BURST_MAX(BURST_MAX), .DW(DW)) dut (
      .clk(clk), .rst(rst), .req(req), .req_dat(req_dat),
      .grant(grant), .accept(accept), .fifo_push(fifo_push),
      .fifo_dat_in(fifo_dat_in), .fifo_full(fifo_full),
      .owner_id(owner_id), .busy(busy)
`ifdef FIFO_ARB_STATS_EN
      , .push_cnt(push_cnt), .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic refresh();
      for (int i = 0; i < NUM_REQ; i++) begin
         if (en[i] && src_q[i].size() > 0) begin
            req[i] = 1'b1;
            req_dat[i*DW +: DW] = src_q[i][0];
         end else begin
            req[i] = 1'b0;
            req_dat[i*DW +: DW] = 32'd0;
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
         n_errors++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic load(input int i, input logic [31:0] base, input int n);
      for (int j = 0; j < n; j++) src_q[i].push_back(base + 32'(j));
   endtask

   task automatic expect_words(input int i, input logic [31:0] base, input int n);
      exp_t e;
      for (int j = 0; j < n; j++) begin
         e.idx = 2'(i);
         e.dat = base + 32'(j);
         exp_q.push_back(e);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      en = 4'b0000;
      fifo_full = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
      refresh();
      tick();
      tick();
      rst = 1'b0;
      refresh();
   endtask

   task automatic drain();
      for (int n = 0; n < 100 && exp_q.size() > 0; n++) tick();
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      repeat (3) tick();
   endtask

   // Requester model: advance a requester's data after an accepted word.
   initial begin
      forever begin
         @(negedge clk);
         drv_adv = accept;
         @(posedge clk);
         #1;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (drv_adv[i] && src_q[i].size() > 0) drv_dummy = src_q[i].pop_front();
         end
         refresh();
      end
   end

   // Monitor: every push must match the next expected word and owner.
   initial begin
      forever begin
         @(negedge clk);
         if (fifo_push === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL unexpected_push: got data %0h accept %b expected no push", fifo_dat_in, accept);
               n_errors++;
            end else begin
               mon_e = exp_q.pop_front();
               if (fifo_dat_in !== mon_e.dat) begin
                  $display("FAIL push_data: got %0h expected %0h", fifo_dat_in, mon_e.dat);
                  n_errors++;
               end
               n_checks++;
               if (accept !== (4'b0001 << mon_e.idx)) begin
                  $display("FAIL push_accept: got %b expected %b", accept, 4'b0001 << mon_e.idx);
                  n_errors++;
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      req = 4'b0000;
      req_dat = '0;
      fifo_full = 1'b0;
      en = 4'b0000;

      // Reset state
      do_reset();
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_owner", 32'(owner_id), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_push", 32'(fifo_push), 32'h0);

      // Single requester 1, six words
      load(1, 32'hA0, 6);
      expect_words(1, 32'hA0, 6);
      en[1] = 1'b1;
      refresh();
      tick();
      chk("single_grant", 32'(grant), 32'h2);
      chk("single_owner", 32'(owner_id), 32'h1);
      chk("single_busy", 32'(busy), 32'h1);
      repeat (4) tick();
      chk("single_bubble", 32'(grant), 32'h0);
      chk("single_bubble_busy", 32'(busy), 32'h0);
      tick();
      chk("single_regrant", 32'(grant), 32'h2);
      drain();

      // Round robin with all four requesting
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) load(i, 32'h100 * 32'(i + 1), (i == 0) ? 8 : 4);
      for (int i = 0; i < NUM_REQ; i++) expect_words(i, 32'h100 * 32'(i + 1), 4);
      expect_words(0, 32'h104, 4);
      en = 4'b1111;
      refresh();
      for (int b = 0; b < 5; b++) begin
         tick();
         chk("rr_grant", 32'(grant), 32'h1 << (b % 4));
         chk("rr_owner", 32'(owner_id), 32'(b % 4));
         repeat (4) tick();
         chk("rr_bubble", 32'(grant), 32'h0);
      end
      drain();

      // Back-pressure on owner 2 after its second push
      do_reset();
      load(2, 32'hC0, 6);
      expect_words(2, 32'hC0, 6);
      en[2] = 1'b1;
      refresh();
      tick();
      chk("bp_grant", 32'(grant), 32'h4);
      tick();
      tick();
      fifo_full = 1'b1;
      for (int s = 0; s < 3; s++) begin
         #1;
         chk("bp_stall_push", 32'(fifo_push), 32'h0);
         chk("bp_stall_accept", 32'(accept), 32'h0);
         chk("bp_stall_owner", 32'(owner_id), 32'h2);
         tick();
      end
      fifo_full = 1'b0;
      #1;
      chk("bp_resume_push", 32'(fifo_push), 32'h1);
      tick();
      tick();
      chk("bp_release", 32'(grant), 32'h0);
      tick();
      chk("bp_regrant", 32'(grant), 32'h4);
      drain();

      // Early drop by owner 0 while requester 3 waits
      do_reset();
      load(0, 32'hE0, 3);
      load(3, 32'hF0, 2);
      expect_words(0, 32'hE0, 1);
      expect_words(3, 32'hF0, 2);
      en = 4'b1001;
      refresh();
      tick();
      chk("drop_grant0", 32'(grant), 32'h1);
      tick();
      en[0] = 1'b0;
      refresh();
      #1;
      chk("drop_no_push", 32'(fifo_push), 32'h0);
      tick();
      chk("drop_bubble", 32'(grant), 32'h0);
      chk("drop_bubble_busy", 32'(busy), 32'h0);
      tick();
      chk("drop_grant3", 32'(grant), 32'h8);
      chk("drop_owner3", 32'(owner_id), 32'h3);
      drain();

      // Reset during owner 1's third push
      do_reset();
      load(1, 32'h70, 4);
      expect_words(1, 32'h70, 2);
      en[1] = 1'b1;
      refresh();
      tick();
      chk("mrst_grant", 32'(grant), 32'h2);
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("mrst_push", 32'(fifo_push), 32'h0);
      chk("mrst_accept", 32'(accept), 32'h0);
      tick();
      chk("mrst_grant0", 32'(grant), 32'h0);
      chk("mrst_owner0", 32'(owner_id), 32'h0);
      chk("mrst_busy0", 32'(busy), 32'h0);
      rst = 1'b0;
      load(0, 32'h80, 1);
      en[0] = 1'b1;
      refresh();
      expect_words(0, 32'h80, 1);
      expect_words(1, 32'h72, 2);
      tick();
      chk("mrst_rearb", 32'(grant), 32'h1);
      drain();

`ifdef FIFO_ARB_STATS_EN
      // Statistics: 10 pushes with 3 stalled cycles
      do_reset();
      chk("stats_rst_push", push_cnt, 32'd0);
      chk("stats_rst_stall", stall_cnt, 32'd0);
      load(0, 32'h90, 10);
      expect_words(0, 32'h90, 10);
      en[0] = 1'b1;
      refresh();
      tick();
      tick();
      tick();
      fifo_full = 1'b1;
      repeat (3) tick();
      fifo_full = 1'b0;
      drain();
      chk("stats_push", push_cnt, 32'd10);
      chk("stats_stall", stall_cnt, 32'd3);
      do_reset();
      chk("stats_clr_push", push_cnt, 32'd0);
      chk("stats_clr_stall", stall_cnt, 32'd0);
`endif

      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/fifo_rr_arbiter.md
Name: fifo_rr_arbiter

Overview:
Round-robin burst arbiter that shares one `fifo` instance's write port among NUM_REQ requesters (e.g. PE rows or DMA channels feeding a FlexArray input queue).
- Grants ownership to one requester at a time.
- Forwards the owner's words as `fifo` push/dat_in, honouring `is_full` back-pressure.
- Rotates ownership after the owner drops its request or reaches BURST_MAX pushes.
- Sits between requester logic and the `fifo` push side; the pop side is untouched.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- BURST_MAX, 4, max words pushed per grant before forced rotation (≥1).
- DW, 32, data width per requester.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester request; bit i high = requester i has a valid word on its data slice.
- req_dat  input  NUM_REQ*DW  flattened requester data; slice i = bits [i*DW +: DW].
- grant  output  NUM_REQ  one-hot owner indicator (registered).
- accept  output  NUM_REQ  one-hot; bit i high = requester i's word is pushed this cycle; requester advances its data on that edge.
- fifo_push  output  1  to `fifo` push.
- fifo_dat_in  output  DW  to `fifo` dat_in.
- fifo_full  input  1  from `fifo` is_full.
- owner_id  output  $clog2(NUM_REQ)  index of the current owner; 0 when idle.
- busy  output  1  high while in BUSY.

Behaviour:
- Reset (rst high at an edge): state=IDLE, grant=0, owner_id=0, rr_ptr=0, burst_cnt=0, busy=0.
  - fifo_push and accept are forced 0 combinationally while rst=1, even mid-burst.
  - A word presented during the reset cycle is not pushed.
- State machine: IDLE, BUSY.
- IDLE:
  - If any req bit is set, select the first set bit scanning from rr_ptr upward with wrap (rr_ptr, rr_ptr+1 … NUM_REQ-1, 0 …).
  - Next edge: owner_id=sel, grant=onehot(sel), burst_cnt=0, state=BUSY.
  - No push occurs in IDLE. Arbitration latency is 1 cycle from req to grant.
- BUSY, push condition: `fifo_push = req[owner] & ~fifo_full`. Then:
  - fifo_dat_in = owner's slice; otherwise fifo_dat_in = 0.
  - accept = grant when pushing, else 0.
  - Each push increments burst_cnt.
- BUSY, release when either holds:
  - (a) req[owner]=0 in the cycle; or
  - (b) a push occurs with burst_cnt==BURST_MAX-1.
- On release, next edge: state=IDLE, grant=0, owner_id=0, burst_cnt=0, rr_ptr=(owner+1) mod NUM_REQ.
  - One bubble cycle always separates grants.
- fifo_full=1 in BUSY: no push, no accept, burst_cnt holds, owner retained. Stalls are not counted toward the burst and do not release.
- Simultaneous requests: only the owner is served; the others wait. Starvation bound = (NUM_REQ-1)*(BURST_MAX+1) non-stalled cycles.
- Requests from non-owners during BUSY are ignored until IDLE.
- Mid-burst req deassert: that cycle has no push and release occurs.
- rr_ptr wraps modulo NUM_REQ. For non-power-of-two NUM_REQ, wrap explicitly at NUM_REQ-1.

Optional Feature:
- Macro: FIFO_ARB_STATS_EN.
- With the macro: adds outputs `push_cnt` (32-bit, total pushes) and `stall_cnt` (32-bit, BUSY cycles with req[owner]=1 and fifo_full=1).
  - Both reset to 0 and wrap at 2^32.
- Without the macro: neither port nor counter exists. All other behaviour is identical.

Test Plan:
- Single requester: NUM_REQ=4, BURST_MAX=4, req=4'b0010 held, data 0xA0..0xA5.
  - grant=4'b0010 one cycle after req.
  - 4 pushes 0xA0..0xA3, then one idle cycle, then regrant to req 1, pushes 0xA4, 0xA5.
- Round-robin fairness: req=4'b1111 held.
  - Grant order 0,1,2,3,0; each burst is 4 pushes; one bubble between bursts.
- Back-pressure: owner 2 pushing, fifo_full=1 for 3 cycles after its 2nd push.
  - No push or accept for those 3 cycles, burst_cnt stays 2.
  - After fifo_full drops, exactly 2 more pushes, then release.
- Early drop: owner 0 drops req after 1 push while req[3]=1.
  - Release next edge; rr_ptr=1; req 3 granted after the bubble.
- Reset mid-burst: rst=1 during owner 1's 3rd push cycle.
  - fifo_push=0 that cycle; next cycle grant=0, owner_id=0, busy=0; after rst low, re-arbitration starts from requester 0.
- FIFO_ARB_STATS_EN defined: 10 pushes and 3 stalled cycles → push_cnt=10, stall_cnt=3; both 0 after reset.
